// File: rtl/input_debounce_bank.sv
// Input conditioner: per-channel synchroniser, tick-gated debounce, edge pulses,
// sticky event flags with software clear, and a masked registered interrupt.
module input_debounce_bank #(
  parameter int unsigned     N_CH           = 21,
  parameter int unsigned     SYNC_STAGES    = 2,
  parameter int unsigned     DEBOUNCE_TICKS = 4,
  parameter logic [N_CH-1:0] RESET_VAL      = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_tick,
  input  logic [N_CH-1:0] i_raw,
  input  logic [N_CH-1:0] i_rise_en,
  input  logic [N_CH-1:0] i_fall_en,
  input  logic [N_CH-1:0] i_clr,
  input  logic [N_CH-1:0] i_mask,
  output logic [N_CH-1:0] o_state,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_event,
  output logic            o_irq
);

  localparam int unsigned     CNT_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [N_CH-1:0]  sync [SYNC_STAGES];
  logic [N_CH-1:0]  s;
  logic [CNT_W-1:0] cnt      [N_CH];
  logic [CNT_W-1:0] cnt_next [N_CH];
  logic [N_CH-1:0]  state_next;
  logic [N_CH-1:0]  rise_next;
  logic [N_CH-1:0]  fall_next;
  logic [N_CH-1:0]  event_next;

  assign s = sync[SYNC_STAGES-1];

  // Debounce decision: any sample equal to the stable level discards progress.
  always_comb begin
    state_next = o_state;
    rise_next  = '0;
    fall_next  = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      cnt_next[c] = cnt[c];
      if (s[c] == o_state[c]) begin
        cnt_next[c] = '0;
      end else if (i_tick) begin
        if (cnt[c] == CNT_LAST) begin
          cnt_next[c]   = '0;
          state_next[c] = s[c];
          rise_next[c]  = s[c];
          fall_next[c]  = ~s[c];
        end else begin
          cnt_next[c] = cnt[c] + CNT_W'(1);
        end
      end
    end
    // A new edge overrides a same-cycle clear so no event is lost.
    event_next = (o_event & ~i_clr) | (rise_next & i_rise_en) | (fall_next & i_fall_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '{default: RESET_VAL};
      cnt     <= '{default: '0};
      o_state <= RESET_VAL;
      o_rise  <= '0;
      o_fall  <= '0;
      o_event <= '0;
      o_irq   <= 1'b0;
    end else begin
      sync[0] <= i_raw;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync[k] <= sync[k-1];
      end
      cnt     <= cnt_next;
      o_state <= state_next;
      o_rise  <= rise_next;
      o_fall  <= fall_next;
      o_event <= event_next;
      o_irq   <= |(o_event & i_mask);
    end
  end

endmodule

// File: tb/tb_input_debounce_bank.sv
// Bench for input_debounce_bank: directed scenarios with literal expectations,
// plus a per-cycle comparison against a run-length behavioural model.
module tb_input_debounce_bank;

  localparam int N = 21;
  localparam int S = 2;
  localparam int D = 4;
  localparam logic [N-1:0] RV = '0;

  logic         clk;
  logic         rst;
  logic         tick;
  logic [N-1:0] raw, rise_en, fall_en, clr, mask;
  logic [N-1:0] o_state, o_rise, o_fall, o_event;
  logic         o_irq;

  int checks = 0;
  int errors = 0;

  // Model: delay line as a queue, per-channel count of consecutive qualifying ticks.
  logic [N-1:0] m_pipe[$];
  int           m_run [N];
  logic [N-1:0] m_state, m_rise, m_fall, m_event;
  logic         m_irq;

  input_debounce_bank #(
    .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_TICKS(D), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst(rst), .i_tick(tick), .i_raw(raw),
    .i_rise_en(rise_en), .i_fall_en(fall_en), .i_clr(clr), .i_mask(mask),
    .o_state(o_state), .o_rise(o_rise), .o_fall(o_fall),
    .o_event(o_event), .o_irq(o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] s;
    if (rst) begin
      m_pipe.delete();
      repeat (S) m_pipe.push_back(RV);
      foreach (m_run[c]) m_run[c] = 0;
      m_state = RV;
      m_rise  = '0;
      m_fall  = '0;
      m_event = '0;
      m_irq   = 1'b0;
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(raw);
      m_irq  = |(m_event & mask);
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < N; c++) begin
        if (s[c] == m_state[c]) begin
          m_run[c] = 0;
        end else if (tick) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_run[c]   = 0;
            m_state[c] = s[c];
            if (s[c]) m_rise[c] = 1'b1;
            else      m_fall[c] = 1'b1;
          end
        end
      end
      m_event = (m_event & ~clr) | (m_rise & rise_en) | (m_fall & fall_en);
    end
  endtask

  // One clock: model follows the active edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("mdl_state", 32'(o_state), 32'(m_state));
    chk("mdl_rise",  32'(o_rise),  32'(m_rise));
    chk("mdl_fall",  32'(o_fall),  32'(m_fall));
    chk("mdl_event", 32'(o_event), 32'(m_event));
    chk("mdl_irq",   32'(o_irq),   32'(m_irq));
  endtask

  initial begin
    int rise3;
    rst = 1'b1; tick = 1'b1; raw = '0;
    rise_en = '0; fall_en = '0; clr = '0; mask = '0;

    // Reset held for three edges, then no spurious pulses with raw at reset level.
    repeat (3) cyc();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_rise",  32'(o_rise),  32'd0);
    chk("rst_fall",  32'(o_fall),  32'd0);
    chk("rst_event", 32'(o_event), 32'd0);
    chk("rst_irq",   32'(o_irq),   32'd0);
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc();
      chk("idle_rise", 32'(o_rise), 32'd0);
    end

    rise_en = '1; fall_en = '1; mask = N'(1);

    // Clean press on ch0: accept after edge S+D = 6, irq one edge later.
    raw[0] = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      cyc();
      if (j == 5) chk("press_state5", 32'(o_state[0]), 32'd0);
      if (j == 6) begin
        chk("press_state6", 32'(o_state[0]), 32'd1);
        chk("press_rise6",  32'(o_rise[0]),  32'd1);
        chk("press_event6", 32'(o_event[0]), 32'd1);
        chk("press_irq6",   32'(o_irq),      32'd0);
      end
      if (j == 7) begin
        chk("press_rise7", 32'(o_rise[0]), 32'd0);
        chk("press_irq7",  32'(o_irq),     32'd1);
      end
    end

    // Bounce on ch3: 3-cycle highs and lows never qualify; final hold gives one pulse.
    rise3 = 0;
    for (int p = 0; p < 4; p++) begin
      raw[3] = (p % 2 == 0);
      repeat (3) begin
        cyc();
        rise3 += int'(o_rise[3]);
      end
    end
    chk("bounce_state", 32'(o_state[3]), 32'd0);
    raw[3] = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      rise3 += int'(o_rise[3]);
      if (j == 5) chk("bounce_state5", 32'(o_state[3]), 32'd0);
      if (j == 6) chk("bounce_rise6",  32'(o_rise[3]),  32'd1);
    end
    chk("bounce_pulses", 32'(rise3), 32'd1);

    // Tick every 4th edge on ch5: sync settles by edge 3, ticks at 4,8,12,16.
    raw[5] = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick = (j % 4 == 0);
      cyc();
      if (j == 15) chk("tick_state15", 32'(o_state[5]), 32'd0);
      if (j == 16) begin
        chk("tick_state16", 32'(o_state[5]), 32'd1);
        chk("tick_rise16",  32'(o_rise[5]),  32'd1);
      end
    end
    tick = 1'b1;

    // Release ch0 with a clear landing on the accepting edge: set must win.
    raw[0] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      cyc();
      if (j == 5) begin
        chk("coll_state5", 32'(o_state[0]), 32'd1);
        clr[0] = 1'b1;
      end
      if (j == 6) begin
        chk("coll_fall6",  32'(o_fall[0]),  32'd1);
        chk("coll_event6", 32'(o_event[0]), 32'd1);
        clr[0] = 1'b0;
      end
    end
    chk("coll_irq", 32'(o_irq), 32'd1);
    clr[0] = 1'b1;
    cyc();
    chk("clr_event", 32'(o_event[0]), 32'd0);
    chk("clr_irq_hold", 32'(o_irq), 32'd1);
    clr[0] = 1'b0;
    cyc();
    chk("clr_irq_drop", 32'(o_irq), 32'd0);

    // Reset while ch1 has cnt=2: progress lost, full latency afterwards.
    raw[1] = 1'b1;
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_state", 32'(o_state[1]), 32'd0);
    chk("midrst_rise",  32'(o_rise[1]),  32'd0);
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      cyc();
      if (j < 6) chk("midrst_norise", 32'(o_rise[1]), 32'd0);
      if (j == 5) chk("midrst_state5", 32'(o_state[1]), 32'd0);
      if (j == 6) begin
        chk("midrst_state6", 32'(o_state[1]), 32'd1);
        chk("midrst_rise6",  32'(o_rise[1]),  32'd1);
      end
    end

    // Mixed traffic on all channels, checked against the model every cycle.
    for (int j = 0; j < 400; j++) begin
      raw     = raw ^ (N'($urandom) & N'($urandom) & N'($urandom));
      tick    = ($urandom_range(0, 3) != 0);
      clr     = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
      rise_en = N'($urandom) | N'($urandom);
      fall_en = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 15) == 0) mask = N'($urandom);
      rst     = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;
    repeat (10) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
